// File: rtl/otter_cu_fsm.sv
// rtl/otter_cu_fsm.sv - OTTER RV32I multicycle control sequencer with memory handshakes and interrupts
module otter_cu_fsm #(
  parameter int INIT_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] ir6_0,
  input  logic [2:0] ir14_12,
  input  logic       imem_rdy,
  input  logic       dmem_rdy,
  input  logic       intr,
  input  logic       mie,
  output logic       PC_RST,
  output logic       PC_WRITE,
  output logic       REG_WRITE,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       MEM_WE2,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC,
  output logic       ILLEGAL_OP,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Last value of the INIT counter before moving on to the first fetch
  localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);

  state_t     state;
  state_t     nxt;
  logic [7:0] init_cnt;
  logic       done;

  assign state_o = state;

  // Output decode and next-state selection; "done" marks the PC_WRITE cycle that ends an instruction
  always_comb begin
    PC_RST     = 1'b0;
    PC_WRITE   = 1'b0;
    REG_WRITE  = 1'b0;
    MEM_RDEN1  = 1'b0;
    MEM_RDEN2  = 1'b0;
    MEM_WE2    = 1'b0;
    CSR_WE     = 1'b0;
    INT_TAKEN  = 1'b0;
    MRET_EXEC  = 1'b0;
    ILLEGAL_OP = 1'b0;
    done       = 1'b0;
    nxt        = state;
    case (state)
      ST_INIT: begin
        PC_RST = 1'b1;
        if (init_cnt == INIT_LAST) nxt = ST_FETCH;
      end
      ST_FETCH: begin
        MEM_RDEN1 = 1'b1;
        if (imem_rdy) nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (ir6_0)
          OP_LOAD: begin
            // Read strobe held through the ready cycle; the register write happens in WB
            MEM_RDEN2 = 1'b1;
            if (dmem_rdy) nxt = ST_WB;
          end
          OP_STORE: begin
            // Write strobe held while waiting; the PC only advances once memory accepts
            MEM_WE2 = 1'b1;
            if (dmem_rdy) begin
              PC_WRITE = 1'b1;
              done     = 1'b1;
            end
          end
          OP_BRANCH: begin
            PC_WRITE = 1'b1;
            done     = 1'b1;
          end
          OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            REG_WRITE = 1'b1;
            PC_WRITE  = 1'b1;
            done      = 1'b1;
          end
          OP_SYSTEM: begin
            if (ir14_12 == 3'b000) begin
              MRET_EXEC = 1'b1;
            end else begin
              CSR_WE    = 1'b1;
              REG_WRITE = 1'b1;
            end
            PC_WRITE = 1'b1;
            done     = 1'b1;
          end
          default: begin
            // Undefined opcodes retire as a NOP so the core keeps running
            ILLEGAL_OP = 1'b1;
            PC_WRITE   = 1'b1;
            done       = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        REG_WRITE = 1'b1;
        PC_WRITE  = 1'b1;
        done      = 1'b1;
      end
      ST_INTR: begin
        // No interrupt check here, so a trap entry can never chain into another
        INT_TAKEN = 1'b1;
        PC_WRITE  = 1'b1;
        nxt       = ST_FETCH;
      end
      default: nxt = ST_INIT;
    endcase
    // Interrupts are only taken on an instruction boundary
    if (done) nxt = (intr && mie) ? ST_INTR : ST_FETCH;
  end

  // State register and INIT hold counter; counter runs only while INIT persists
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_INIT;
      init_cnt <= 8'd0;
    end else begin
      state <= nxt;
      if (state == ST_INIT && nxt == ST_INIT) init_cnt <= init_cnt + 8'd1;
      else                                    init_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb/tb_otter_cu_fsm.sv - randomized sequence check of otter_cu_fsm against an instruction-level model
module tb_otter_cu_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] ir6_0 = '0;
  logic [2:0] ir14_12 = '0;
  logic       imem_rdy = 1'b0;
  logic       dmem_rdy = 1'b0;
  logic       intr = 1'b0;
  logic       mie = 1'b0;
  logic       pc_rst, pc_write, reg_write, rden1, rden2, we2, csr_we, int_taken, mret, illegal;
  logic [2:0] state_o;

  int tests = 0;
  int fails = 0;

  otter_cu_fsm #(.INIT_CYCLES(3)) dut (
    .CLK(clk), .RST_N(rst_n), .ir6_0(ir6_0), .ir14_12(ir14_12),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .intr(intr), .mie(mie),
    .PC_RST(pc_rst), .PC_WRITE(pc_write), .REG_WRITE(reg_write),
    .MEM_RDEN1(rden1), .MEM_RDEN2(rden2), .MEM_WE2(we2), .CSR_WE(csr_we),
    .INT_TAKEN(int_taken), .MRET_EXEC(mret), .ILLEGAL_OP(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {state_o, pc_rst, pc_write, reg_write, rden1, rden2, we2,
                csr_we, int_taken, mret, illegal};

  // Instruction classes as the ISA groups them
  typedef enum int {C_LOAD, C_STORE, C_BRANCH, C_REGW, C_MRET, C_CSR, C_ILL} cls_t;

  function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: return C_REGW;
      7'b1110011: return (f3 == 3'b000) ? C_MRET : C_CSR;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [12:0] mk(input int st, input bit pcr, pcw, rw, r1, r2, we,
                                     input bit csr, it, mr, il);
    logic [2:0] s;
    s = 3'(st);
    return {s, pcr, pcw, rw, r1, r2, we, csr, it, mr, il};
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, advance to just after the next edge
  task automatic step(input string tag, input bit im, dm, it, me, input logic [12:0] exp);
    imem_rdy = im;
    dmem_rdy = dm;
    intr     = it;
    mie      = me;
    @(negedge clk);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // One whole instruction: fw fetch stalls, dw data stalls, (iv,mv) presented in the retire cycle
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fw, dw,
                           input bit iv, mv);
    cls_t c;
    c = classify(op, f3);
    for (int i = 0; i < fw; i++) begin
      ir6_0 = 7'($urandom); ir14_12 = 3'($urandom);
      step("fetch_wait", 0, rb(), rb(), rb(), mk(1, 0,0,0,1,0,0,0,0,0,0));
    end
    ir6_0 = 7'($urandom); ir14_12 = 3'($urandom);
    step("fetch", 1, rb(), rb(), rb(), mk(1, 0,0,0,1,0,0,0,0,0,0));
    ir6_0 = op; ir14_12 = f3;
    case (c)
      C_LOAD: begin
        for (int i = 0; i < dw; i++)
          step("load_wait", rb(), 0, rb(), rb(), mk(2, 0,0,0,0,1,0,0,0,0,0));
        step("load_rdy", rb(), 1, rb(), rb(), mk(2, 0,0,0,0,1,0,0,0,0,0));
        step("wb", rb(), rb(), iv, mv, mk(3, 0,1,1,0,0,0,0,0,0,0));
      end
      C_STORE: begin
        for (int i = 0; i < dw; i++)
          step("store_wait", rb(), 0, rb(), rb(), mk(2, 0,0,0,0,0,1,0,0,0,0));
        step("store_rdy", rb(), 1, iv, mv, mk(2, 0,1,0,0,0,1,0,0,0,0));
      end
      C_BRANCH: step("branch", rb(), rb(), iv, mv, mk(2, 0,1,0,0,0,0,0,0,0,0));
      C_REGW:   step("regw",   rb(), rb(), iv, mv, mk(2, 0,1,1,0,0,0,0,0,0,0));
      C_MRET:   step("mret",   rb(), rb(), iv, mv, mk(2, 0,1,0,0,0,0,0,0,1,0));
      C_CSR:    step("csr",    rb(), rb(), iv, mv, mk(2, 0,1,1,0,0,0,1,0,0,0));
      default:  step("illegal",rb(), rb(), iv, mv, mk(2, 0,1,0,0,0,0,0,0,0,1));
    endcase
    if (iv && mv)
      step("intr", rb(), rb(), rb(), rb(), mk(4, 0,1,0,0,0,0,0,1,0,0));
  endtask

  logic [6:0] op_tbl [10];
  logic [6:0] op;

  initial begin
    op_tbl = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011,
               7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011};

    // Reset held two cycles, then three INIT cycles before the first fetch
    #1;
    step("rst_hold0", 1, 1, 1, 1, mk(0, 1,0,0,0,0,0,0,0,0,0));
    step("rst_hold1", 0, 1, 0, 1, mk(0, 1,0,0,0,0,0,0,0,0,0));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step("init", rb(), rb(), rb(), rb(), mk(0, 1,0,0,0,0,0,0,0,0,0));

    // Directed cases
    run_instr(7'b0010011, 3'b000, 0, 0, 0, 0);  // ADDI
    run_instr(7'b0000011, 3'b010, 0, 2, 0, 0);  // LW, two data stalls
    run_instr(7'b0100011, 3'b010, 0, 1, 0, 0);  // SW, one data stall
    run_instr(7'b1100011, 3'b000, 0, 0, 1, 1);  // BEQ with interrupt taken
    run_instr(7'b1100011, 3'b000, 0, 0, 1, 0);  // BEQ with interrupt masked
    run_instr(7'b1111111, 3'b000, 0, 0, 0, 0);  // undefined opcode
    run_instr(7'b1110011, 3'b000, 1, 0, 1, 1);  // MRET with intr and mie
    run_instr(7'b1110011, 3'b001, 0, 0, 0, 0);  // CSRRW
    run_instr(7'b0000011, 3'b010, 2, 0, 1, 1);  // LW, interrupt after WB

    // Random instruction stream
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) op = 7'($urandom);
      else                           op = op_tbl[$urandom_range(0, 9)];
      run_instr(op, 3'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb());
    end

    // Asynchronous reset in the middle of a load wait
    ir6_0 = 7'b0000011; ir14_12 = 3'b010;
    step("mid_fetch", 1, 0, 0, 0, mk(1, 0,0,0,1,0,0,0,0,0,0));
    step("mid_load_wait", 0, 0, 0, 0, mk(2, 0,0,0,0,1,0,0,0,0,0));
    dmem_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    assert (obs === mk(0, 1,0,0,0,0,0,0,0,0,0)) else begin
      fails++;
      $error("FAIL async_reset observed=%b expected=%b", obs, mk(0, 1,0,0,0,0,0,0,0,0,0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step("reinit", rb(), rb(), rb(), rb(), mk(0, 1,0,0,0,0,0,0,0,0,0));
    run_instr(7'b0110011, 3'b000, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
